// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake. Results are held until the next division completes.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Extra top bit of the trial subtraction is the borrow.
  always_comb begin
    shifted = {prem, work[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      work        <= '0;
      dvs         <= '0;
      prem        <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= dividend;
            dvs   <= divisor;
            prem  <= '0;
            count <= CW'(WIDTH);
            state <= (divisor == '0) ? FINISH : RUN;
          end
        end
        RUN: begin
          // Quotient bits shift into the low end of work as dividend bits leave the top.
          if (trial[WIDTH]) begin
            prem <= shifted[WIDTH-1:0];
            work <= {work[WIDTH-2:0], 1'b0};
          end else begin
            prem <= trial[WIDTH-1:0];
            work <= {work[WIDTH-2:0], 1'b1};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
          // A zero divisor skips RUN, so work still holds the captured dividend.
          if (dvs == '0) begin
            quotient    <= '1;
            remainder   <= work;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= work;
            remainder   <= prem;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
